// File: rtl/alu_operand_stage.sv
// ALU operand stage: resolves MEM/WB forwarding at accept time and buffers
// registered a/b/funct/sa operands in a two-entry skid buffer for the ALU.
package selector;
  typedef enum logic [3:0] {
    ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_function;
endpackage

module alu_operand_stage #(
  parameter  int N     = 32,
  parameter  int REG_W = 5,
  localparam int SA_W  = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_W-1:0]      in_rs_id,
  input  logic [REG_W-1:0]      in_rt_id,
  input  logic [N-1:0]          in_rs_val,
  input  logic [N-1:0]          in_rt_val,
  input  logic                  in_use_imm,
  input  logic [N-1:0]          in_imm,
  input  selector::alu_function in_funct,
  input  logic [SA_W-1:0]       in_shamt,
  input  logic                  in_sa_from_rs,
  input  logic [REG_W-1:0]      in_dest,
  input  logic                  in_dest_we,
  input  logic                  fwd_mem_we,
  input  logic                  fwd_wb_we,
  input  logic [REG_W-1:0]      fwd_mem_id,
  input  logic [REG_W-1:0]      fwd_wb_id,
  input  logic [N-1:0]          fwd_mem_val,
  input  logic [N-1:0]          fwd_wb_val,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N-1:0]          out_a,
  output logic [N-1:0]          out_b,
  output selector::alu_function out_funct,
  output logic [SA_W-1:0]       out_sa,
  output logic [REG_W-1:0]      out_dest,
  output logic                  out_dest_we
);

  typedef struct packed {
    logic [N-1:0]          a;
    logic [N-1:0]          b;
    selector::alu_function funct;
    logic [SA_W-1:0]       sa;
    logic [REG_W-1:0]      dest;
    logic                  dest_we;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  localparam entry_t ENTRY_RST = '{a: '0, b: '0, funct: selector::ALU_AND,
                                   sa: '0, dest: '0, dest_we: 1'b0};

  state_t       state;
  entry_t       main_q;
  entry_t       skid_q;
  entry_t       in_entry;
  logic [N-1:0] rs_fwd;
  logic [N-1:0] rt_fwd;
  logic         accept;
  logic         pop;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // Register 0 is hardwired, so it never takes a bypass value.
  always_comb begin
    rs_fwd = in_rs_val;
    rt_fwd = in_rt_val;
    if (in_rs_id != '0) begin
      if (fwd_mem_we && (fwd_mem_id == in_rs_id))
        rs_fwd = fwd_mem_val;
      else if (fwd_wb_we && (fwd_wb_id == in_rs_id))
        rs_fwd = fwd_wb_val;
    end
    if (in_rt_id != '0) begin
      if (fwd_mem_we && (fwd_mem_id == in_rt_id))
        rt_fwd = fwd_mem_val;
      else if (fwd_wb_we && (fwd_wb_id == in_rt_id))
        rt_fwd = fwd_wb_val;
    end
    in_entry.a       = rs_fwd;
    in_entry.b       = in_use_imm ? in_imm : rt_fwd;
    in_entry.funct   = in_funct;
    in_entry.sa      = in_sa_from_rs ? rs_fwd[SA_W-1:0] : in_shamt;
    in_entry.dest    = in_dest;
    in_entry.dest_we = in_dest_we;
  end

  // in_ready and out_valid are flops tracking state, so out_ready never
  // reaches in_ready combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      main_q    <= ENTRY_RST;
      skid_q    <= ENTRY_RST;
    end else if (flush) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q    <= in_entry;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            skid_q   <= in_entry;
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (accept && pop) begin
            main_q <= in_entry;
          end else if (pop) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        FULL: begin
          if (pop) begin
            main_q   <= skid_q;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_a       = main_q.a;
  assign out_b       = main_q.b;
  assign out_funct   = main_q.funct;
  assign out_sa      = main_q.sa;
  assign out_dest    = main_q.dest;
  assign out_dest_we = main_q.dest_we;

endmodule
